// File: rtl/speck_uart_cmd_ctrl.sv
// Byte-level command sequencer between the UART RX/TX byte streams and a Speck block core.
// It assembles a command frame, runs the core under a watchdog, and streams the result back.
module speck_uart_cmd_ctrl #(
    parameter int         W           = 32,
    parameter int         TIMEOUT_CYC = 1024,
    parameter logic [7:0] CMD_ENC     = 8'h45,
    parameter logic [7:0] CMD_DEC     = 8'h44,
    parameter logic [7:0] ERR_BYTE    = 8'hEE
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic         core_start,
    output logic         core_decrypt,
    output logic [W-1:0] core_in_x,
    output logic [W-1:0] core_in_y,
    input  logic         core_done,
    input  logic [W-1:0] core_out_x,
    input  logic [W-1:0] core_out_y,
    output logic         busy,
    output logic         rx_drop,
    output logic         timeout_err
);

    localparam int NB = (2 * W) / 8;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] LAST_BYTE = CW'(NB - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX,
        S_START,
        S_WAIT,
        S_TX,
        S_ERR
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [2*W-1:0]  shift_q, shift_d;
    logic [2*W-1:0]  blk_q, blk_d;
    logic [2*W-1:0]  out_q, out_d;
    logic            cmd_dec_q, cmd_dec_d;
    logic            dec_q, dec_d;
    logic            drop_q, drop_d;

    // The command's direction is held aside until START so core_decrypt stays
    // stable for the whole previous transaction while the next frame arrives.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        shift_d     = shift_q;
        blk_d       = blk_q;
        out_d       = out_q;
        cmd_dec_d   = cmd_dec_q;
        dec_d       = dec_q;
        drop_d      = drop_q;
        core_start  = 1'b0;
        tx_valid    = 1'b0;
        tx_data     = 8'h00;
        timeout_err = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rx_valid && (rx_data == CMD_ENC || rx_data == CMD_DEC)) begin
                    cmd_dec_d = (rx_data == CMD_DEC);
                    cnt_d     = '0;
                    state_d   = S_RX;
                end
            end
            S_RX: begin
                if (rx_valid) begin
                    shift_d = {shift_q[2*W-9:0], rx_data};
                    if (cnt_q == LAST_BYTE) begin
                        blk_d   = {shift_q[2*W-9:0], rx_data};
                        dec_d   = cmd_dec_q;
                        cnt_d   = '0;
                        state_d = S_START;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_START: begin
                core_start = 1'b1;
                tmo_d      = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                // A result arriving on the expiry cycle still counts as success.
                if (core_done) begin
                    out_d   = {core_out_x, core_out_y};
                    cnt_d   = '0;
                    state_d = S_TX;
                end else if (tmo_q == TMO_LAST) begin
                    timeout_err = 1'b1;
                    state_d     = S_ERR;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_TX: begin
                tx_valid = 1'b1;
                tx_data  = out_q[2*W-1 -: 8];
                if (tx_ready) begin
                    out_d = {out_q[2*W-9:0], 8'h00};
                    if (cnt_q == LAST_BYTE) begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_ERR: begin
                tx_valid = 1'b1;
                tx_data  = ERR_BYTE;
                if (tx_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (rx_valid && (state_q == S_START || state_q == S_WAIT ||
                         state_q == S_TX || state_q == S_ERR)) begin
            drop_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            tmo_q     <= '0;
            shift_q   <= '0;
            blk_q     <= '0;
            out_q     <= '0;
            cmd_dec_q <= 1'b0;
            dec_q     <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            shift_q   <= shift_d;
            blk_q     <= blk_d;
            out_q     <= out_d;
            cmd_dec_q <= cmd_dec_d;
            dec_q     <= dec_d;
            drop_q    <= drop_d;
        end
    end

    assign core_in_x    = blk_q[2*W-1:W];
    assign core_in_y    = blk_q[W-1:0];
    assign core_decrypt = dec_q;
    assign busy         = (state_q != S_IDLE);
    assign rx_drop      = drop_q;

endmodule

// File: tb/tb_speck_uart_cmd_ctrl.sv
// Directed bench for speck_uart_cmd_ctrl: the core is played by hand-scheduled
// done pulses returning the published Speck-64/128 test vector.
module tb_speck_uart_cmd_ctrl;

    localparam logic [63:0] PT = 64'h3b726574_7475432d;
    localparam logic [63:0] CT = 64'h8c6fa548_454e028b;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        core_start;
    logic        core_decrypt;
    logic [31:0] core_in_x;
    logic [31:0] core_in_y;
    logic        core_done;
    logic [31:0] core_out_x;
    logic [31:0] core_out_y;
    logic        busy;
    logic        rx_drop;
    logic        timeout_err;

    int n_vec;
    int n_err;

    speck_uart_cmd_ctrl #(
        .W          (32),
        .TIMEOUT_CYC(16),
        .CMD_ENC    (8'h45),
        .CMD_DEC    (8'h44),
        .ERR_BYTE   (8'hEE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .core_start  (core_start),
        .core_decrypt(core_decrypt),
        .core_in_x   (core_in_x),
        .core_in_y   (core_in_y),
        .core_done   (core_done),
        .core_out_x  (core_out_x),
        .core_out_y  (core_out_y),
        .busy        (busy),
        .rx_drop     (rx_drop),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL global_timeout: observed hang expected finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [63:0] blk);
        send_byte(cmd);
        for (int i = 0; i < 8; i++) begin
            send_byte(blk[63-8*i -: 8]);
        end
    endtask

    // Called at the negedge right after the last data byte was accepted.
    task automatic check_start(input logic dec, input logic [63:0] blk);
        check_output("core_start_pulse", 64'(core_start), 64'd1);
        check_output("core_decrypt", 64'(core_decrypt), 64'(dec));
        check_output("core_in_x", 64'(core_in_x), 64'(blk[63:32]));
        check_output("core_in_y", 64'(core_in_y), 64'(blk[31:0]));
        tick();
        check_output("core_start_single", 64'(core_start), 64'd0);
    endtask

    task automatic core_reply(input logic [63:0] res, input int delay);
        repeat (delay) tick();
        core_done  = 1'b1;
        core_out_x = res[63:32];
        core_out_y = res[31:0];
        tick();
        core_done  = 1'b0;
        core_out_x = 32'h0;
        core_out_y = 32'h0;
    endtask

    task automatic recv_byte(input logic [7:0] exp, input int stall);
        int k;
        k = 0;
        while (!tx_valid && k < 50) begin
            tick();
            k++;
        end
        check_output("tx_valid_wait", 64'(tx_valid), 64'd1);
        repeat (stall) begin
            tx_ready = 1'b0;
            check_output("tx_data_stall", 64'(tx_data), 64'(exp));
            tick();
        end
        check_output("tx_data", 64'(tx_data), 64'(exp));
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
    endtask

    task automatic recv_block(input logic [63:0] blk, input int stall);
        for (int i = 0; i < 8; i++) begin
            recv_byte(blk[63-8*i -: 8], stall);
        end
        check_output("idle_after_tx_busy", 64'(busy), 64'd0);
        check_output("idle_after_tx_valid", 64'(tx_valid), 64'd0);
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        rst        = 1'b1;
        rx_data    = 8'h00;
        rx_valid   = 1'b0;
        tx_ready   = 1'b0;
        core_done  = 1'b0;
        core_out_x = 32'h0;
        core_out_y = 32'h0;
        repeat (2) tick();

        check_output("rst_busy", 64'(busy), 64'd0);
        check_output("rst_tx_valid", 64'(tx_valid), 64'd0);
        check_output("rst_tx_data", 64'(tx_data), 64'd0);
        check_output("rst_core_start", 64'(core_start), 64'd0);
        check_output("rst_core_in", {core_in_x, core_in_y}, 64'd0);
        check_output("rst_core_decrypt", 64'(core_decrypt), 64'd0);
        check_output("rst_rx_drop", 64'(rx_drop), 64'd0);
        check_output("rst_timeout_err", 64'(timeout_err), 64'd0);
        rst = 1'b0;
        tick();

        $display("[TB] encrypt vector");
        send_frame(8'h45, PT);
        check_output("busy_in_start", 64'(busy), 64'd1);
        check_start(1'b0, PT);
        core_reply(CT, 1);
        recv_block(CT, 0);

        $display("[TB] decrypt vector");
        send_frame(8'h44, CT);
        check_start(1'b1, CT);
        core_reply(PT, 2);
        recv_block(PT, 0);

        $display("[TB] junk bytes then encrypt under backpressure");
        send_byte(8'h00);
        send_byte(8'h41);
        check_output("junk_rx_drop", 64'(rx_drop), 64'd0);
        check_output("junk_busy", 64'(busy), 64'd0);
        send_frame(8'h45, PT);
        check_start(1'b0, PT);
        core_reply(CT, 1);
        recv_block(CT, 2);

        $display("[TB] watchdog timeout");
        send_frame(8'h45, PT);
        check_start(1'b0, PT);
        repeat (14) tick();
        check_output("tmo_early", 64'(timeout_err), 64'd0);
        tick();
        check_output("tmo_pulse", 64'(timeout_err), 64'd1);
        check_output("tmo_tx_valid_wait", 64'(tx_valid), 64'd0);
        tick();
        check_output("tmo_pulse_single", 64'(timeout_err), 64'd0);
        recv_byte(8'hEE, 1);
        check_output("tmo_idle", 64'(busy), 64'd0);
        core_done  = 1'b1;
        core_out_x = 32'hdeadbeef;
        core_out_y = 32'hcafef00d;
        tick();
        core_done  = 1'b0;
        check_output("late_done_busy", 64'(busy), 64'd0);
        tick();
        check_output("late_done_tx_valid", 64'(tx_valid), 64'd0);

        $display("[TB] overflow during wait, then reset mid-transmit");
        send_frame(8'h45, PT);
        check_start(1'b0, PT);
        send_byte(8'h55);
        check_output("ovf_rx_drop", 64'(rx_drop), 64'd1);
        check_output("ovf_busy", 64'(busy), 64'd1);
        core_reply(CT, 0);
        recv_block(CT, 0);
        check_output("ovf_rx_drop_sticky", 64'(rx_drop), 64'd1);
        send_frame(8'h45, PT);
        check_start(1'b0, PT);
        core_reply(CT, 1);
        for (int i = 0; i < 4; i++) begin
            recv_byte(CT[63-8*i -: 8], 0);
        end
        rst = 1'b1;
        tick();
        check_output("midtx_rst_tx_valid", 64'(tx_valid), 64'd0);
        check_output("midtx_rst_rx_drop", 64'(rx_drop), 64'd0);
        check_output("midtx_rst_busy", 64'(busy), 64'd0);
        check_output("midtx_rst_core_in", {core_in_x, core_in_y}, 64'd0);
        rst = 1'b0;
        tick();
        send_frame(8'h45, PT);
        check_start(1'b0, PT);
        core_reply(CT, 1);
        recv_block(CT, 0);

        $display("[TB] done coincides with watchdog expiry");
        send_frame(8'h45, PT);
        check_start(1'b0, PT);
        repeat (15) tick();
        core_done  = 1'b1;
        core_out_x = CT[63:32];
        core_out_y = CT[31:0];
        #1;
        check_output("coinc_no_timeout", 64'(timeout_err), 64'd0);
        tick();
        core_done  = 1'b0;
        core_out_x = 32'h0;
        core_out_y = 32'h0;
        check_output("coinc_tx_valid", 64'(tx_valid), 64'd1);
        recv_block(CT, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
